// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state, nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [1:0]           op_q;

    logic accept, mt_wr, abort, fix_exit;
    logic in_signed, q_signed, q_div, neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign accept   = (state == S_IDLE) && start && !cancel && !op[2];
    assign mt_wr    = (state == S_IDLE) && start && !cancel && (op == 3'd4 || op == 3'd5);
    assign abort    = cancel && (state != S_IDLE);
    assign fix_exit = (state == S_FIX) && !cancel;

    // |x| in WIDTH bits: the most negative value maps to itself as unsigned
    assign in_signed = !op[0];
    assign mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;

    assign q_signed  = !op_q[0];
    assign q_div     = op_q[1];
    assign neg       = q_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (accept) nxt = S_RUN;
            S_RUN:  if (cnt == CW'(WIDTH-1)) nxt = S_FIX;
            S_FIX:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // One iteration step; acc is {partial, multiplier} for MUL and {remainder, quotient} for DIV
    logic [WIDTH:0] sum, t, diff;
    logic           ge;
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
        t       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = t - {1'b0, addend};
        ge      = (t >= {1'b0, addend});
        acc_nxt = {sum, acc[WIDTH-1:1]};
        if (q_div)
            acc_nxt = {(ge ? diff[WIDTH-1:0] : t[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
    always_comb begin
        prod   = neg ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (q_div) begin
            if (b_q == '0) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_lo = neg ? -quo : quo;
                fix_hi = (q_signed && a_q[WIDTH-1]) ? -rem : rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            HI     <= '0;
            LO     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            addend <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
        end else begin
            done <= fix_exit;
            if (accept) begin
                a_q    <= A;
                b_q    <= B;
                op_q   <= op[1:0];
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                addend <= op[1] ? mag_b : mag_a;
            end else if (state == S_RUN && !cancel) begin
                cnt <= cnt + 1'b1;
                acc <= acc_nxt;
            end
            if (fix_exit) begin
                HI <= fix_hi;
                LO <= fix_lo;
            end
            if (mt_wr) begin
                if (op == 3'd4) HI <= A;
                else            LO <= A;
            end
        end
    end

endmodule
